adder_subtractor_seq: RTL

Parametrised, multi-cycle successor to the 4-bit ripple adder/subtractor. It takes WIDTH-bit operands and processes one CHUNK-bit slice per clock. The slice carry is held in a register between cycles, so WIDTH scales without a long combinational carry chain. The block sits in the datapath behind a valid/ready handshake and returns the result together with carry, signed-overflow, zero and negative flags.

---
 rtl/adder_subtractor_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adder_subtractor_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered slice carry.
// Optional build macro ADDSUB_SEQ_SAT_EN clamps the final result on signed overflow.
module adder_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sel_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             neg_reg;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] bx_slice;
  logic [CHUNK-1:0] sum_slice;
  logic             slice_cout;
  logic             msb_cin;
  logic             ovf_calc;
  logic             last_slice;
  logic [WIDTH-1:0] s_merged;
  logic [WIDTH-1:0] s_final;

  // Pick the active operand slices by chunk index.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (int'(idx_reg) == i) begin
        a_slice = a_reg[i*CHUNK +: CHUNK];
        b_slice = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    bx_slice                = b_slice ^ {CHUNK{sel_reg}};
    {slice_cout, sum_slice} = {1'b0, a_slice} + {1'b0, bx_slice} + {{CHUNK{1'b0}}, carry_reg};
    // Carry into the MSB recovered from the sum bit and its operands.
    msb_cin    = sum_slice[CHUNK-1] ^ a_slice[CHUNK-1] ^ bx_slice[CHUNK-1];
    ovf_calc   = msb_cin ^ slice_cout;
    last_slice = (int'(idx_reg) == NCHUNK - 1);
  end

  // Full result with the slice being computed this cycle merged in.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_merge
      assign s_merged[gi*CHUNK +: CHUNK] =
        (int'(idx_reg) == gi) ? sum_slice : s_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

`ifdef ADDSUB_SEQ_SAT_EN
  assign s_final = ovf_calc ? (a_reg[WIDTH-1] ? MIN_NEG : MAX_POS) : s_merged;
`else
  assign s_final = s_merged;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            sel_reg   <= sel;
            carry_reg <= sel;
            idx_reg   <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          carry_reg <= slice_cout;
          if (last_slice) begin
            s_reg     <= s_final;
            cout_reg  <= slice_cout;
            ovf_reg   <= ovf_calc;
            zero_reg  <= (s_final == '0);
            neg_reg   <= s_final[WIDTH-1];
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            s_reg   <= s_merged;
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign S         = s_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;

endmodule
